// File: rtl/fgcg_pipe_scheduler.sv
// Fine-grained clock-gating scheduler for an N-stage valid/ready pipeline, plus a
// domain-level RUN/HOLD/GATED/WAKE controller that gates the whole pipeline when idle.
module fgcg_pipe_scheduler #(
  parameter int STAGES    = 4,
  parameter int IDLE_HOLD = 8,
  parameter int WAKE_CYC  = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              force_on,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] occ,
  output logic              domain_en,
  output logic [1:0]        state
);

  localparam int CNT_MAX = (IDLE_HOLD > WAKE_CYC) ? IDLE_HOLD : WAKE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(IDLE_HOLD - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_GATED = 2'd0,
    ST_WAKE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [STAGES-1:0] occ_r;
  logic              domain_en_r;
  logic [STAGES:0]   acc_s;
  logic [STAGES-1:0] stage_en_s;
  logic [STAGES-1:0] leave_s;
  logic              run_s;
  logic              in_ready_s;
  logic              busy_s;

  // Acceptance chain; acc_s[STAGES] stands for the downstream consumer.
  always_comb begin
    acc_s = '0;
    acc_s[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc_s[i] = ~occ_r[i] | acc_s[i+1];
    end
  end

  // Per-stage capture enables and departures; a stage that holds still keeps its clock off.
  always_comb begin
    run_s      = (state_r == ST_RUN) || (state_r == ST_HOLD);
    in_ready_s = acc_s[0] & run_s;
    stage_en_s = '0;
    leave_s    = '0;
    stage_en_s[0] = in_valid & in_ready_s;
    for (int i = 1; i < STAGES; i++) begin
      stage_en_s[i] = occ_r[i-1] & acc_s[i];
    end
    for (int i = 0; i < STAGES; i++) begin
      leave_s[i] = occ_r[i] & acc_s[i+1];
    end
    busy_s = (|occ_r) | in_valid | force_on;
  end

  // Domain FSM next-state and idle/wake countdown.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (!busy_s) begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_LOAD;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (busy_s) begin
          state_s = ST_RUN;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_GATED;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_GATED: begin
        if (in_valid || force_on) begin
          state_s = ST_WAKE;
          cnt_s   = WAKE_LOAD;
        end else begin
          state_s = ST_GATED;
        end
      end
      ST_WAKE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_RUN;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_GATED;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, occupancy and the registered domain enable.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r     <= ST_GATED;
      cnt_r       <= CNT_ZERO;
      occ_r       <= '0;
      domain_en_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      occ_r       <= stage_en_s | (occ_r & ~leave_s);
      domain_en_r <= (state_s != ST_GATED);
    end
  end

  assign in_ready  = in_ready_s;
  assign stage_en  = stage_en_s;
  assign occ       = occ_r;
  assign out_valid = occ_r[STAGES-1];
  assign domain_en = domain_en_r;
  assign state     = state_r;

endmodule

// File: tb/tb_fgcg_pipe_scheduler.sv
// Scoreboard bench: a slot-level pipeline model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the scheduler.
module tb_fgcg_pipe_scheduler;

  localparam int S  = 4;
  localparam int IH = 8;
  localparam int WC = 2;
  localparam int VW = 2 * S + 5;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         force_on = 1'b0;
  logic [S-1:0] stage_en;
  logic [S-1:0] occ;
  logic         domain_en;
  logic [1:0]   state;

  fgcg_pipe_scheduler #(.STAGES(S), .IDLE_HOLD(IH), .WAKE_CYC(WC)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .force_on(force_on),
    .stage_en(stage_en), .occ(occ), .domain_en(domain_en), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [VW-1:0] exp_q[$];

  // Reference model: item ids per slot (-1 = empty), domain mode and its countdown.
  int         slot[S];
  logic [1:0] ms;
  int         mcnt;
  int         next_id;
  bit         pend;

  function automatic logic [VW-1:0] dut_vec();
    return {state, domain_en, in_ready, out_valid, occ, stage_en};
  endfunction

  // Monitor: each cycle the stimulus pushed an expectation, compare it mid-cycle.
  always @(negedge clk) begin
    logic [VW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (dut_vec() !== e) begin
        miscompares++;
        $display("FAIL cycle_vec t=%0t got {st,den,ir,ov,occ,en}=%b expected %b", $time, dut_vec(), e);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < S; i++) slot[i] = -1;
    ms = 2'd0;
    mcnt = 0;
    pend = 1'b0;
  endtask

  task automatic chk_reset(input string name);
    vectors++;
    if (dut_vec() !== {VW{1'b0}}) begin
      miscompares++;
      $display("FAIL %s got %b expected %b", name, dut_vec(), {VW{1'b0}});
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    force_on = 1'b0;
    rstb = 1'b0;
    #1;
    chk_reset("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_held");
    rstb = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict outputs by moving items, advance the model.
  task automatic step(input bit iv_req, input bit ordy, input bit fo);
    int nslot[S];
    logic [S-1:0] en, occ_e;
    bit run, rdy, iv, busy;
    iv = iv_req | pend;
    in_valid = iv;
    out_ready = ordy;
    force_on = fo;
    run = (ms == 2'd2) || (ms == 2'd3);
    en = '0;
    for (int i = 0; i < S; i++) begin
      nslot[i] = -1;
      occ_e[i] = (slot[i] >= 0);
    end
    if (slot[S-1] >= 0 && !ordy) nslot[S-1] = slot[S-1];
    for (int k = S - 2; k >= 0; k--) begin
      if (slot[k] >= 0) begin
        if (nslot[k+1] < 0) begin
          nslot[k+1] = slot[k];
          en[k+1] = 1'b1;
        end else begin
          nslot[k] = slot[k];
        end
      end
    end
    rdy = run && (nslot[0] < 0);
    if (iv && rdy) begin
      nslot[0] = next_id;
      next_id++;
      en[0] = 1'b1;
      pend = 1'b0;
    end else begin
      pend = iv;
    end
    exp_q.push_back({ms, (ms != 2'd0), rdy, occ_e[S-1], occ_e, en});
    busy = (occ_e != '0) || iv || fo;
    case (ms)
      2'd2: if (!busy) begin ms = 2'd3; mcnt = IH - 1; end
      2'd3: begin
        if (busy) ms = 2'd2;
        else if (mcnt == 0) ms = 2'd0;
        else mcnt--;
      end
      2'd0: if (iv || fo) begin ms = 2'd1; mcnt = WC - 1; end
      default: begin
        if (mcnt == 0) ms = 2'd2;
        else mcnt--;
      end
    endcase
    slot = nslot;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    bit fo_r;
    next_id = 0;
    model_reset();
    #1;
    chk_reset("power_on_reset");
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;

    // Idle after reset stays gated; then wake-up and first acceptance.
    repeat (6) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0);

    // Streaming 20 items, then drain.
    repeat (20) step(1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    // Backpressure: fill and stall, then release.
    repeat (6) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    // Bubble compaction from 0101 with downstream stalled.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    // Input arriving mid-HOLD, then full idle to gate.
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0);

    // force_on wakes and holds the domain, then it idles back down.
    repeat (10) step(1'b0, 1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b1, 1'b0);

    // Mid-operation reset discards in-flight data.
    step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    do_reset();
    @(posedge clk);
    #1;
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // Randomized traffic alternating busy and sparse phases so gating recurs.
    fo_r = 1'b0;
    for (int blk = 0; blk < 12; blk++) begin
      p = (blk % 2 == 1) ? 55 : 3;
      repeat (250) begin
        if ($urandom_range(0, 99) < 2) fo_r = ~fo_r;
        step($urandom_range(0, 99) < p, $urandom_range(0, 99) < 70, fo_r);
      end
    end
    repeat (30) step(1'b0, 1'b1, 1'b0);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
